// File: rtl/dec3to8_grant_pkg.sv
// Shared definitions for the registered 3-to-8 grant decoder.
//   - FSM state encoding (IDLE / GRANT / COOL)
//   - Default grant timeout and timer width
package dec3to8_grant_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] COOL  = 2'd2;

  // Maximum cycles a grant is held without ack; legal range 2..255.
  localparam int TIMEOUT_DEFAULT = 8;

  // Timer holds values up to TIMEOUT-1 <= 254, so it never wraps.
  localparam int TIMER_W = 8;

endpackage

// File: rtl/dec3to8.sv
// Combinational 3-to-8 one-hot decoder with enable.
// Ports:
//   en   in  1 : when low the output is all zeros
//   sel  in  3 : index of the line to raise
//   dout out 8 : one-hot (en=1) or zero (en=0)
module dec3to8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] dout
);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_line
      assign dout[gi] = en & (sel == 3'(gi));
    end
  endgenerate

endmodule

// File: rtl/dec3to8_grant.sv
// Registered 3-to-8 grant decoder. Captures an encoded index from an
// upstream priority encoder, raises the matching one-hot grant line and
// holds it until ack or until TIMEOUT cycles pass, then spends one cool-down
// cycle before accepting the next index.
// Ports:
//   clk     in  1 : clock, rising edge
//   rst_n   in  1 : synchronous active-low reset
//   EN      in  1 : block enable; low returns to idle (idx is kept)
//   valid   in  1 : Y carries a meaningful index (used only in IDLE)
//   Y       in  3 : encoded index
//   ack     in  1 : consumer accepted the grant (used only in GRANT)
//   G       out 8 : one-hot grant, zero when no grant is active
//   idx     out 3 : index of the current or most recent grant
//   busy    out 1 : high in GRANT and COOL
//   timeout out 1 : one-cycle pulse when a grant expires without ack
module dec3to8_grant
  import dec3to8_grant_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       EN,
  input  logic       valid,
  input  logic [2:0] Y,
  input  logic       ack,
  output logic [7:0] G,
  output logic [2:0] idx,
  output logic       busy,
  output logic       timeout
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  state_t               state_reg;
  logic [TIMER_W-1:0]   timer_reg;
  logic [7:0]           g_reg;
  logic [2:0]           idx_reg;
  logic                 busy_reg;
  logic                 timeout_reg;
  logic [7:0]           g_next;

  // Decoded grant value loaded on capture; only meaningful in IDLE.
  dec3to8 u_dec (
    .en   (valid),
    .sel  (Y),
    .dout (g_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      g_reg       <= '0;
      idx_reg     <= '0;
      busy_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else if (!EN) begin
      // Disable aborts any grant but keeps the last captured index visible.
      state_reg   <= IDLE;
      timer_reg   <= '0;
      g_reg       <= '0;
      busy_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (valid) begin
            idx_reg   <= Y;
            g_reg     <= g_next;
            timer_reg <= '0;
            busy_reg  <= 1'b1;
            state_reg <= GRANT;
          end
        end
        GRANT: begin
          // ack has priority over expiry: no timeout pulse when both occur.
          if (ack) begin
            g_reg     <= '0;
            state_reg <= COOL;
          end else if (timer_reg == TIMER_LAST) begin
            g_reg       <= '0;
            timeout_reg <= 1'b1;
            state_reg   <= COOL;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        COOL: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          g_reg     <= '0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign G       = g_reg;
  assign idx     = idx_reg;
  assign busy    = busy_reg;
  assign timeout = timeout_reg;

endmodule
